// File: rtl/risc_spm_pkg.sv
// Shared RISC-SPM definitions: memory word/address widths (also used by the
// processing and memory units) and the program loader's state encoding.
package risc_spm_pkg;

  localparam int DATAWIDTH = 8;
  localparam int ADDRWIDTH = 8;

  typedef logic [2:0] state_t;

  localparam state_t GET_LEN  = 3'd0;
  localparam state_t GET_DATA = 3'd1;
  localparam state_t WRITE    = 3'd2;
  localparam state_t GET_SUM  = 3'd3;
  localparam state_t DONE     = 3'd4;
  localparam state_t ERROR    = 3'd5;

  // States in which the loader is willing to take a stream byte.
  function automatic logic is_rx_state(input state_t s);
    return (s == GET_LEN) || (s == GET_DATA) || (s == GET_SUM);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Loader stream + memory write bus.
//   rx_data/rx_valid/rx_ready : byte stream, transfer on rx_valid && rx_ready
//   mem_address/mem_data_out/mem_write : RAM write port driven by the loader
// master = stream source / memory side, slave = the loader itself.
interface program_loader_if #(
  parameter int DATAWIDTH = risc_spm_pkg::DATAWIDTH,
  parameter int ADDRWIDTH = risc_spm_pkg::ADDRWIDTH
) ();
  logic [DATAWIDTH-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [ADDRWIDTH-1:0] mem_address;
  logic [DATAWIDTH-1:0] mem_data_out;
  logic                 mem_write;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_address, mem_data_out, mem_write
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_address, mem_data_out, mem_write
  );
endinterface

// File: rtl/loader_checksum.sv
// 8-bit (W-bit) running sum of payload bytes, mod 2^W.
//   clk     : clock
//   clr_i   : synchronous clear (has priority over add)
//   add_i   : accumulate data_i this cycle
//   data_i  : byte to add / byte to compare against
//   match_o : accumulated sum equals data_i
module loader_checksum
  import risc_spm_pkg::*;
#(
  parameter int W = DATAWIDTH
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         add_i,
  input  logic [W-1:0] data_i,
  output logic         match_o
);

  logic [W-1:0] sum_q, sum_d;

  // Wraps naturally at W bits, which is the mod-256 checksum rule.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return a + b;
  endfunction

  always_comb begin
    sum_d = sum_q;
    if (add_i) sum_d = wrap_add(sum_q, data_i);
  end

  always_ff @(posedge clk) begin
    if (clr_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign match_o = (sum_q == data_i);

endmodule

// File: rtl/program_loader.sv
// Boot loader ahead of the RISC-SPM memory unit. Receives LEN, LEN payload
// bytes, SUM on a valid/ready stream, writes the payload to RAM from
// START_ADDR upward (wrapping), and releases the CPU only after the sum
// matches.
//   clk, clr : clock and synchronous active-high reset
//   start    : re-arm from DONE/ERROR
//   bus      : stream input and RAM write port (slave modport)
//   cpu_clr  : holds processing/control units in clear while high
//   busy     : loader owns the memory port
//   done     : image loaded, checksum good
//   error    : checksum mismatch
module program_loader #(
  parameter int DATAWIDTH  = risc_spm_pkg::DATAWIDTH,
  parameter int ADDRWIDTH  = risc_spm_pkg::ADDRWIDTH,
  parameter int START_ADDR = 0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  program_loader_if.slave bus,
  output logic            cpu_clr,
  output logic            busy,
  output logic            done,
  output logic            error
);
  import risc_spm_pkg::*;

  localparam logic [ADDRWIDTH-1:0] START = ADDRWIDTH'(START_ADDR);

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] count_q, count_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic                 wr_q, wr_d;
  logic                 cpu_clr_q, cpu_clr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic rx_ready;
  logic xfer;
  logic sum_clr;
  logic sum_add;
  logic sum_match;

  // Ready is the only combinational output; clr forces it low so no byte
  // can slip in on a reset edge.
  assign rx_ready = ~clr & is_rx_state(state_q);
  assign xfer     = bus.rx_valid & rx_ready;
  assign sum_clr  = clr | ((state_q == GET_LEN) & xfer);
  assign sum_add  = (state_q == GET_DATA) & xfer;

  loader_checksum #(.W(DATAWIDTH)) u_checksum (
    .clk     (clk),
    .clr_i   (sum_clr),
    .add_i   (sum_add),
    .data_i  (bus.rx_data),
    .match_o (sum_match)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    data_d    = data_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    cpu_clr_d = cpu_clr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    case (state_q)
      GET_LEN: if (xfer) begin
        count_d = bus.rx_data;
        addr_d  = START;
        state_d = (bus.rx_data == '0) ? GET_SUM : GET_DATA;
      end
      GET_DATA: if (xfer) begin
        data_d  = bus.rx_data;
        wr_d    = 1'b1;
        state_d = WRITE;
      end
      // RAM captures on the edge that leaves this state.
      WRITE: begin
        wr_d    = 1'b0;
        addr_d  = addr_q + ADDRWIDTH'(1);
        count_d = count_q - DATAWIDTH'(1);
        state_d = (count_q == DATAWIDTH'(1)) ? GET_SUM : GET_DATA;
      end
      GET_SUM: if (xfer) begin
        if (sum_match) begin
          state_d   = DONE;
          cpu_clr_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          state_d = ERROR;
          error_d = 1'b1;
        end
      end
      DONE, ERROR: if (start) begin
        state_d   = GET_LEN;
        cpu_clr_d = 1'b1;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        error_d   = 1'b0;
      end
      default: state_d = GET_LEN;
    endcase
  end

  // ---- control registers (reset) ----
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= GET_LEN;
      count_q   <= '0;
      addr_q    <= START;
      wr_q      <= 1'b0;
      cpu_clr_q <= 1'b1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      cpu_clr_q <= cpu_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // ---- write data register (no reset, qualified by mem_write) ----
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign bus.rx_ready     = rx_ready;
  assign bus.mem_address  = addr_q;
  assign bus.mem_data_out = data_q;
  assign bus.mem_write    = wr_q;
  assign cpu_clr          = cpu_clr_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic cpu_clr0, busy0, done0, error0;
  logic cpu_clr1, busy1, done1, error1;

  int checks = 0;
  int errors = 0;

  program_loader_if bus0 ();
  program_loader_if bus1 ();

  assign bus0.rx_data  = rx_data;
  assign bus0.rx_valid = rx_valid;
  assign bus1.rx_data  = rx_data;
  assign bus1.rx_valid = rx_valid;

  program_loader #(.START_ADDR(0)) dut0 (
    .clk(clk), .clr(clr), .start(start), .bus(bus0),
    .cpu_clr(cpu_clr0), .busy(busy0), .done(done0), .error(error0)
  );

  program_loader #(.START_ADDR(8'hFE)) dut1 (
    .clk(clk), .clr(clr), .start(start), .bus(bus1),
    .cpu_clr(cpu_clr1), .busy(busy1), .done(done1), .error(error1)
  );

  always #5 clk = ~clk;

  // Frame-level model: position within the frame, running sum, pending write.
  bit         m_on = 0;
  int         m_idx = 0;
  int         m_len = 0;
  int         m_sum = 0;
  bit         m_wr = 0;
  bit         m_ok = 0;
  bit         m_err = 0;
  logic [7:0] m_wd, m_wa0, m_wa1;
  logic [7:0] mram0[256];
  logic [7:0] mram1[256];
  logic [7:0] ram0[256];
  logic [7:0] ram1[256];
  int         wcnt0 = 0;
  int         wcnt1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (clr) begin
      m_on = 1; m_idx = 0; m_sum = 0; m_wr = 0; m_ok = 0; m_err = 0;
    end else if (m_ok || m_err) begin
      if (start) begin m_ok = 0; m_err = 0; m_idx = 0; end
    end else if (m_wr) begin
      m_wr = 0;
    end else if (rx_valid) begin
      if (m_idx == 0) begin
        m_len = int'(rx_data); m_sum = 0; m_idx = 1;
      end else if (m_idx <= m_len) begin
        m_wr  = 1;
        m_wd  = rx_data;
        m_wa0 = 8'(m_idx - 1);
        m_wa1 = 8'(254 + m_idx - 1);
        mram0[m_wa0] = rx_data;
        mram1[m_wa1] = rx_data;
        m_sum = m_sum + int'(rx_data);
        m_idx++;
      end else begin
        if (rx_data == 8'(m_sum)) m_ok = 1;
        else                      m_err = 1;
      end
    end
  end

  // Per-cycle compare, away from the active edge; also records RAM writes.
  always @(negedge clk) begin
    if (m_on) begin
      chk("rx_ready0", 32'(bus0.rx_ready), 32'(!clr && !m_wr && !m_ok && !m_err));
      chk("rx_ready1", 32'(bus1.rx_ready), 32'(!clr && !m_wr && !m_ok && !m_err));
      chk("mem_write0", 32'(bus0.mem_write), 32'(m_wr));
      chk("mem_write1", 32'(bus1.mem_write), 32'(m_wr));
      if (m_wr) begin
        chk("mem_address0", 32'(bus0.mem_address), 32'(m_wa0));
        chk("mem_address1", 32'(bus1.mem_address), 32'(m_wa1));
        chk("mem_data0", 32'(bus0.mem_data_out), 32'(m_wd));
        chk("mem_data1", 32'(bus1.mem_data_out), 32'(m_wd));
      end
      chk("cpu_clr0", 32'(cpu_clr0), 32'(!m_ok));
      chk("busy0", 32'(busy0), 32'(!m_ok));
      chk("done0", 32'(done0), 32'(m_ok));
      chk("error0", 32'(error0), 32'(m_err));
      chk("cpu_clr1", 32'(cpu_clr1), 32'(!m_ok));
      chk("done1", 32'(done1), 32'(m_ok));
      chk("error1", 32'(error1), 32'(m_err));
      if (bus0.mem_write === 1'b1) begin ram0[bus0.mem_address] = bus0.mem_data_out; wcnt0++; end
      if (bus1.mem_write === 1'b1) begin ram1[bus1.mem_address] = bus1.mem_data_out; wcnt1++; end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int idle);
    logic rdy;
    int   n;
    rx_valid = 1'b0;
    repeat (idle) step();
    rx_valid = 1'b1;
    rx_data  = b;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 40) begin
      @(negedge clk);
      rdy = bus0.rx_ready;
      step();
      n++;
    end
    rx_valid = 1'b0;
    chk("send_accepted", 32'(rdy), 32'd1);
  endtask

  task automatic send_frame(input bq_t f, input int idle_max);
    foreach (f[i]) send(f[i], (idle_max > 0) ? int'($urandom_range(0, idle_max)) : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int w;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mram0[i] = 8'h00; mram1[i] = 8'h00; ram0[i] = 8'h00; ram1[i] = 8'h00;
    end
    clr = 1'b1;
    step();
    step();
    #1;
    chk("reset_rx_ready_in_clr", 32'(bus0.rx_ready), 32'd0);
    clr = 1'b0;
    #1;
    chk("reset_cpu_clr", 32'(cpu_clr0), 32'd1);
    chk("reset_busy", 32'(busy0), 32'd1);
    chk("reset_done", 32'(done0), 32'd0);
    chk("reset_mem_write", 32'(bus0.mem_write), 32'd0);
    chk("reset_rx_ready_after", 32'(bus0.rx_ready), 32'd1);

    // 1: A1+B2+C3 = 0x216 -> sum byte 16
    send_frame('{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16}, 0);
    chk("t1_done", 32'(done0), 32'd1);
    chk("t1_cpu_clr", 32'(cpu_clr0), 32'd0);
    chk("t1_busy", 32'(busy0), 32'd0);
    chk("t1_ram00", 32'(ram0[0]), 32'hA1);
    chk("t1_ram01", 32'(ram0[1]), 32'hB2);
    chk("t1_ram02", 32'(ram0[2]), 32'hC3);
    chk("t1_writes", 32'(wcnt0), 32'd3);

    // 2: bad checksum
    pulse_start();
    send_frame('{8'h02, 8'h10, 8'h20, 8'h31}, 0);
    chk("t2_error", 32'(error0), 32'd1);
    chk("t2_done", 32'(done0), 32'd0);
    chk("t2_cpu_clr", 32'(cpu_clr0), 32'd1);
    chk("t2_ram00", 32'(ram0[0]), 32'h10);
    chk("t2_ram01", 32'(ram0[1]), 32'h20);
    start = 1'b1; // start while still a receive-less state is the re-arm
    step();
    start = 1'b0;
    chk("t2_rearm_error", 32'(error0), 32'd0);
    chk("t2_rearm_ready", 32'(bus0.rx_ready), 32'd1);
    pulse_start(); // ignored in GET_LEN

    // 3: empty frames
    w = wcnt0;
    send_frame('{8'h00, 8'h00}, 0);
    chk("t3_done", 32'(done0), 32'd1);
    chk("t3_no_writes", 32'(wcnt0), 32'(w));
    pulse_start();
    send_frame('{8'h00, 8'h01}, 0);
    chk("t3_error", 32'(error0), 32'd1);

    // 4: wrap on the FE-based instance
    pulse_start();
    send_frame('{8'h03, 8'h01, 8'h02, 8'h03, 8'h06}, 0);
    chk("t4_done1", 32'(done1), 32'd1);
    chk("t4_ramFE", 32'(ram1[8'hFE]), 32'h01);
    chk("t4_ramFF", 32'(ram1[8'hFF]), 32'h02);
    chk("t4_ram00", 32'(ram1[8'h00]), 32'h03);

    // 5: clr mid-frame, right after the second payload transfer
    pulse_start();
    send_frame('{8'h04, 8'hAA, 8'hBB}, 0);
    clr = 1'b1;
    #1;
    chk("t5_ready_in_clr", 32'(bus0.rx_ready), 32'd0);
    step();
    clr = 1'b0;
    #1;
    chk("t5_mem_write", 32'(bus0.mem_write), 32'd0);
    chk("t5_cpu_clr", 32'(cpu_clr0), 32'd1);
    chk("t5_ready_after", 32'(bus0.rx_ready), 32'd1);
    send_frame('{8'h01, 8'h55, 8'h55}, 0);
    chk("t5_done", 32'(done0), 32'd1);
    chk("t5_ram00", 32'(ram0[0]), 32'h55);
    chk("t5_ram01_kept", 32'(ram0[1]), 32'hBB);

    // 6: stalls on rx_valid
    pulse_start();
    w = wcnt0;
    send_frame('{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F}, 5);
    chk("t6_done", 32'(done0), 32'd1);
    chk("t6_writes", 32'(wcnt0 - w), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t6_ram0", 32'(ram0[i]), 32'(i + 1));
      chk("t6_ram1", 32'(ram1[8'(254 + i)]), 32'(i + 1));
    end

    step();
    for (int i = 0; i < 256; i++) begin
      chk("final_ram0", 32'(ram0[i]), 32'(mram0[i]));
      chk("final_ram1", 32'(ram1[i]), 32'(mram1[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
